// File: rtl/lbp_pkg.sv
// rtl/lbp_pkg.sv - shared types, window layout and LBP code function for the LBP stream engine
package lbp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DRAIN,
    ST_DONE
  } state_t;

  // Pixels are zero-extended to this width so the code function serves any PIX_W up to 16.
  localparam int MAX_PIX_W = 16;
  typedef logic [MAX_PIX_W-1:0] pix_t;

  // Flattened 3x3 window: index = 3*row + col, row 0 = top, col 0 = left.
  typedef logic [8:0][MAX_PIX_W-1:0] win_t;

  localparam int WIN_CENTRE = 4;
  localparam int NB_POS [8] = '{0, 1, 2, 3, 5, 6, 7, 8};

  function automatic logic [7:0] lbp_code(input win_t win, input pix_t thr);
    logic [MAX_PIX_W:0] lim;
    logic [7:0] code;
    lim  = {1'b0, win[WIN_CENTRE]} + {1'b0, thr};
    code = '0;
    for (int k = 0; k < 8; k++) begin
      code[k] = ({1'b0, win[NB_POS[k]]} >= lim);
    end
    return code;
  endfunction

endpackage

// File: rtl/lbp_line_buffer.sv
// rtl/lbp_line_buffer.sv - fixed-depth pixel delay line advancing only on shift enable
module lbp_line_buffer #(
  parameter int DEPTH = 128,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             shift_en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] taps [DEPTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        taps[i] <= '0;
      end
    end else if (shift_en) begin
      taps[0] <= din;
      for (int i = 1; i < DEPTH; i++) begin
        taps[i] <= taps[i-1];
      end
    end
  end

  // Oldest entry: the pixel accepted exactly DEPTH shifts ago, i.e. same column one row up.
  assign dout = taps[DEPTH-1];

endmodule

// File: rtl/lbp_stream_engine.sv
// rtl/lbp_stream_engine.sv - single-pass raster LBP engine with line buffers and output backpressure
module lbp_stream_engine
  import lbp_pkg::*;
#(
  parameter int IMG_W  = 128,
  parameter int IMG_H  = 128,
  parameter int PIX_W  = 8,
  parameter int ADDR_W = 14
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [PIX_W-1:0]  thr,
  output logic [ADDR_W-1:0] gray_addr,
  output logic              gray_req,
  input  logic              gray_ready,
  input  logic [PIX_W-1:0]  gray_data,
  output logic [ADDR_W-1:0] lbp_addr,
  output logic              lbp_valid,
  input  logic              lbp_ready,
  output logic [7:0]        lbp_data,
  output logic              finish
);

  localparam int COL_W = $clog2(IMG_W);
  localparam int ROW_W = $clog2(IMG_H);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMG_W * IMG_H - 1);
  localparam logic [ADDR_W-1:0] CTR_OFF   = ADDR_W'(IMG_W + 1);
  localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(IMG_W - 1);

  state_t state, state_nxt;

  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  logic [PIX_W-1:0] thr_q;
  logic [PIX_W-1:0] win [3][3];
  logic [PIX_W-1:0] tap1, tap2;
  logic             accept, start_ok, last_pix, win_full, out_take;
  win_t             win_nxt;
  logic [7:0]       code_nxt;

  assign accept   = gray_req && gray_ready;
  assign start_ok = (state == ST_IDLE) && start;
  assign last_pix = (gray_addr == LAST_ADDR);
  assign win_full = (row >= ROW_W'(2)) && (col >= COL_W'(2));
  assign out_take = lbp_valid && lbp_ready;

  lbp_line_buffer #(.DEPTH(IMG_W), .WIDTH(PIX_W)) u_lb_row1 (
    .clk      (clk),
    .reset    (reset),
    .shift_en (accept),
    .din      (gray_data),
    .dout     (tap1)
  );

  lbp_line_buffer #(.DEPTH(IMG_W), .WIDTH(PIX_W)) u_lb_row2 (
    .clk      (clk),
    .reset    (reset),
    .shift_en (accept),
    .din      (tap1),
    .dout     (tap2)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    gray_req  = 1'b0;
    finish    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) state_nxt = ST_FETCH;
      end
      ST_FETCH: begin
        // Stop fetching while a finished code is stuck in the output register.
        gray_req = !(lbp_valid && !lbp_ready);
        if (gray_req && gray_ready && last_pix) state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (!lbp_valid || lbp_ready) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        finish    = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Window as it will look once the incoming pixel has shifted in; the code is taken from it.
  always_comb begin
    for (int r = 0; r < 3; r++) begin
      win_nxt[3*r+0] = pix_t'(win[r][1]);
      win_nxt[3*r+1] = pix_t'(win[r][2]);
    end
    win_nxt[2] = pix_t'(tap2);
    win_nxt[5] = pix_t'(tap1);
    win_nxt[8] = pix_t'(gray_data);
    code_nxt   = lbp_code(win_nxt, pix_t'(thr_q));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      gray_addr <= '0;
      col       <= '0;
      row       <= '0;
      thr_q     <= '0;
      lbp_valid <= 1'b0;
      lbp_addr  <= '0;
      lbp_data  <= '0;
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) begin
          win[r][c] <= '0;
        end
      end
    end else begin
      if (start_ok) begin
        gray_addr <= '0;
        col       <= '0;
        row       <= '0;
        thr_q     <= thr;
      end else if (accept) begin
        if (!last_pix) gray_addr <= gray_addr + ADDR_W'(1);
        if (col == COL_LAST) begin
          col <= '0;
          row <= row + ROW_W'(1);
        end else begin
          col <= col + COL_W'(1);
        end
        for (int r = 0; r < 3; r++) begin
          win[r][0] <= win[r][1];
          win[r][1] <= win[r][2];
        end
        win[0][2] <= tap2;
        win[1][2] <= tap1;
        win[2][2] <= gray_data;
      end

      // Columns 0/1 of the window still hold the previous row, so only c>=2 may emit.
      if (accept && win_full) begin
        lbp_valid <= 1'b1;
        lbp_data  <= code_nxt;
        lbp_addr  <= gray_addr - CTR_OFF;
      end else if (out_take) begin
        lbp_valid <= 1'b0;
      end
    end
  end

endmodule
